// File: rtl/fifo_rr_arbiter_if.sv
// Handshake bundle between the producers/consumer and the round-robin FIFO arbiter.
// The master side is the environment: it drives the producer valids/payloads and the consumer ready.
// The slave side is the arbiter.
interface fifo_rr_arbiter_if #(
    parameter int n_ports = 4,
    parameter int width   = 8,
    parameter int depth   = 8
);
    localparam int id_w  = $clog2(n_ports);
    localparam int cnt_w = $clog2(depth + 1);

    logic [n_ports-1:0]       in_valid;
    logic [n_ports*width-1:0] in_data;
    logic [n_ports-1:0]       in_ready;
    logic                     out_valid;
    logic [width-1:0]         out_data;
    logic [id_w-1:0]          out_id;
    logic                     out_ready;
    logic [cnt_w-1:0]         occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id, occupancy
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter merging n_ports valid/ready producers into one flip-flop FIFO.
// Each entry stores {producer id, payload}; the head entry is presented to a single consumer.
// Pointers carry a wrap-parity bit so full and empty can be told apart at any depth.
module fifo_rr_arbiter #(
    parameter int n_ports = 4,
    parameter int width   = 8,
    parameter int depth   = 8
) (
    input logic             clk,
    input logic             rstn,
    fifo_rr_arbiter_if.slave bus
);
    localparam int id_w  = $clog2(n_ports);
    localparam int cnt_w = $clog2(depth + 1);
    localparam int ptr_w = $clog2(depth);

    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             wr_par;
    logic             rd_par;
    logic [id_w-1:0]  rr_ptr;
    logic [cnt_w-1:0] occ;

    logic [width-1:0] data_mem [depth];
    logic [id_w-1:0]  id_mem   [depth];

    logic               empty;
    logic               full;
    logic               pop;
    logic               space;
    logic               grant_found;
    logic [id_w-1:0]    grant_idx;
    logic [n_ports-1:0] ready_vec;
    logic               push;
    logic [width-1:0]   push_data;

    assign empty = (wr_ptr == rd_ptr) && (wr_par == rd_par);
    assign full  = (wr_ptr == rd_ptr) && (wr_par != rd_par);
    assign pop   = !empty && bus.out_ready;
    // A full FIFO still has room when the head leaves in the same cycle.
    assign space = !full || pop;

    // Scan requesters upward from rr_ptr, wrapping at n_ports; first valid wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < n_ports; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= n_ports) idx = idx - n_ports;
            if (!grant_found && bus.in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = id_w'(idx);
            end
        end
    end

    // Ready goes only to the granted port, only with space, and never during reset.
    always_comb begin
        ready_vec = '0;
        if (rstn && grant_found && space) ready_vec[grant_idx] = 1'b1;
    end

    assign push      = |ready_vec;
    assign push_data = bus.in_data[int'(grant_idx)*width +: width];

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = !empty;
    assign bus.out_data  = data_mem[rd_ptr];
    assign bus.out_id    = id_mem[rd_ptr];
    assign bus.occupancy = occ;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            id_mem[wr_ptr]   <= grant_idx;
        end
    end

    // Pointer, parity, round-robin and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_par <= 1'b0;
            rd_par <= 1'b0;
            rr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                if (wr_ptr == ptr_w'(depth - 1)) begin
                    wr_ptr <= '0;
                    wr_par <= !wr_par;
                end else begin
                    wr_ptr <= wr_ptr + ptr_w'(1);
                end
                // A denied requester never moves the pointer, so it keeps its turn.
                rr_ptr <= (grant_idx == id_w'(n_ports - 1)) ? '0 : grant_idx + id_w'(1);
            end
            if (pop) begin
                if (rd_ptr == ptr_w'(depth - 1)) begin
                    rd_ptr <= '0;
                    rd_par <= !rd_par;
                end else begin
                    rd_ptr <= rd_ptr + ptr_w'(1);
                end
            end
            if (push && !pop)      occ <= occ + cnt_w'(1);
            else if (pop && !push) occ <= occ - cnt_w'(1);
        end
    end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a depth-8 instance for grant order, full/push-through,
// priority retention and reset, and a depth-5 instance compared against a reference queue.
module tb_fifo_rr_arbiter;
    logic clk;
    logic rstn;

    fifo_rr_arbiter_if #(.n_ports(4), .width(8), .depth(8)) m ();
    fifo_rr_arbiter_if #(.n_ports(4), .width(8), .depth(5)) b5 ();

    fifo_rr_arbiter #(.n_ports(4), .width(8), .depth(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (m)
    );

    fifo_rr_arbiter #(.n_ports(4), .width(8), .depth(5)) dut5 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b5)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state for the depth-5 instance.
    logic [9:0] m_q[$];
    int         m_rr   = 0;
    int         pushes = 0;
    int         seq[4] = '{0, 0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_b5(input int n_cyc, input bit rnd);
        logic [3:0] v;
        logic [3:0] acc;
        logic       rdy;
        logic [7:0] d;
        int         sz;
        int         g;
        int         idx;
        bit         space;
        logic [3:0] exp_rdy;
        v   = '0;
        acc = '0;
        for (int c = 0; c < n_cyc; c++) begin
            if (rnd) begin
                for (int p = 0; p < 4; p++)
                    v[p] = (v[p] && !acc[p]) ? 1'b1 : 1'($urandom_range(0, 1));
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                v   = (pushes < 23) ? 4'hF : 4'h0;
                rdy = ((c % 3) != 0);
            end
            for (int p = 0; p < 4; p++)
                b5.in_data[p*8 +: 8] = {2'(p), 6'(seq[p])};
            b5.in_valid  = v;
            b5.out_ready = rdy;

            sz    = m_q.size();
            space = (sz < 5) || (sz > 0 && rdy);
            g     = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_rr + k) % 4;
                if (g < 0 && v[idx]) g = idx;
            end
            exp_rdy = (g >= 0 && space) ? 4'(1 << g) : 4'h0;
            #1;
            chk("b5_ready", 32'(b5.in_ready), 32'(exp_rdy));
            chk("b5_valid", 32'(b5.out_valid), 32'(sz > 0));
            chk("b5_occ", 32'(b5.occupancy), 32'(sz));
            if (sz > 0) begin
                chk("b5_data", 32'(b5.out_data), 32'(m_q[0][7:0]));
                chk("b5_id", 32'(b5.out_id), 32'(m_q[0][9:8]));
            end
            if (sz > 0 && rdy) void'(m_q.pop_front());
            if (exp_rdy != 4'h0) begin
                d = {2'(g), 6'(seq[g])};
                m_q.push_back({2'(g), d});
                seq[g]++;
                m_rr = (g + 1) % 4;
                pushes++;
            end
            acc = exp_rdy;
            tick();
        end
        b5.in_valid = '0;
    endtask

    initial begin
        logic [3:0] exp3[3];
        exp3 = '{4'b0010, 4'b0100, 4'b0010};

        rstn        = 1'b0;
        m.in_valid  = 4'hF;
        m.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        m.out_ready = 1'b1;
        b5.in_valid  = '0;
        b5.in_data   = '0;
        b5.out_ready = 1'b0;

        // Reset state, with every producer requesting.
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(m.in_ready), 32'h0);
        chk("rst_valid", 32'(m.out_valid), 32'h0);
        chk("rst_occ", 32'(m.occupancy), 32'h0);
        chk("rst_rr", 32'(dut.rr_ptr), 32'h0);
        rstn = 1'b1;

        // All four valid and draining: grants rotate 0,1,2,3,0 at occupancy 1.
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rot_grant", 32'(m.in_ready), 32'(1 << (k % 4)));
            if (k == 0) begin
                chk("rot_first_valid", 32'(m.out_valid), 32'h0);
            end else begin
                chk("rot_id", 32'(m.out_id), 32'((k - 1) % 4));
                chk("rot_data", 32'(m.out_data), 32'(8'h10 + (k - 1) % 4));
                chk("rot_occ", 32'(m.occupancy), 32'h1);
            end
            tick();
        end
        m.in_valid = 4'h0;
        #1;
        chk("rot_last_id", 32'(m.out_id), 32'h0);
        chk("rot_last_data", 32'(m.out_data), 32'h10);
        tick();
        #1;
        chk("rot_empty_occ", 32'(m.occupancy), 32'h0);
        chk("rot_empty_valid", 32'(m.out_valid), 32'h0);

        // Port 2 alone fills the FIFO, then push-through at full.
        m.out_ready = 1'b0;
        m.in_valid  = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            m.in_data[16 +: 8] = 8'(32'h20 + i);
            #1;
            chk("fill_ready", 32'(m.in_ready), 32'h4);
            tick();
        end
        #1;
        chk("full_ready", 32'(m.in_ready), 32'h0);
        chk("full_occ", 32'(m.occupancy), 32'h8);
        chk("full_rr", 32'(dut.rr_ptr), 32'h3);
        m.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            m.in_data[16 +: 8] = 8'(32'h28 + j);
            #1;
            chk("pt_ready", 32'(m.in_ready), 32'h4);
            chk("pt_data", 32'(m.out_data), 32'(32'h20 + j));
            chk("pt_occ", 32'(m.occupancy), 32'h8);
            tick();
        end
        m.in_valid = 4'h0;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("drain_data", 32'(m.out_data), 32'(32'h24 + j));
            chk("drain_id", 32'(m.out_id), 32'h2);
            tick();
        end
        #1;
        chk("drain_occ", 32'(m.occupancy), 32'h0);

        // Port 0 fills (rr ends at 1), then ports 1 and 3 wait on a full FIFO.
        m.out_ready = 1'b0;
        m.in_valid  = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            m.in_data[0 +: 8] = 8'(32'h30 + i);
            #1;
            chk("fill0_ready", 32'(m.in_ready), 32'h1);
            tick();
        end
        m.in_valid = 4'b1010;
        #1;
        chk("blk_ready", 32'(m.in_ready), 32'h0);
        tick();
        #1;
        chk("blk_ready2", 32'(m.in_ready), 32'h0);
        chk("blk_rr", 32'(dut.rr_ptr), 32'h1);
        m.out_ready = 1'b1;
        #1;
        chk("blk_pop_grant", 32'(m.in_ready), 32'h2);
        tick();
        #1;
        chk("blk_rr_after", 32'(dut.rr_ptr), 32'h2);
        chk("blk_head", 32'(m.out_data), 32'h31);
        chk("blk_occ", 32'(m.occupancy), 32'h8);
        chk("blk_next_grant", 32'(m.in_ready), 32'h8);

        // Mid-stream reset discards a full FIFO; then reset again at occupancy 3.
        m.out_ready = 1'b0;
        m.in_valid  = 4'b0110;
        rstn = 1'b0;
        #1;
        chk("rst2_ready", 32'(m.in_ready), 32'h0);
        tick();
        rstn = 1'b1;
        #1;
        chk("rst2_occ", 32'(m.occupancy), 32'h0);
        chk("rst2_valid", 32'(m.out_valid), 32'h0);
        chk("rst2_rr", 32'(dut.rr_ptr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) #1;
            chk("p3_grant", 32'(m.in_ready), 32'(exp3[i]));
            tick();
        end
        #1;
        chk("p3_occ", 32'(m.occupancy), 32'h3);
        chk("p3_rr", 32'(dut.rr_ptr), 32'h2);
        rstn = 1'b0;
        #1;
        chk("rst3_ready", 32'(m.in_ready), 32'h0);
        tick();
        rstn       = 1'b1;
        m.in_valid = 4'h0;
        #1;
        chk("rst3_occ", 32'(m.occupancy), 32'h0);
        chk("rst3_valid", 32'(m.out_valid), 32'h0);
        chk("rst3_rr", 32'(dut.rr_ptr), 32'h0);

        // Depth 5: 23 entries under steady push and 2-in-3 pop, then random stalls.
        run_b5(60, 1'b0);
        chk("b5_pushes", 32'(pushes), 32'd23);
        chk("b5_drained", 32'(m_q.size()), 32'h0);
        run_b5(3000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
